// File: rtl/adsr_pkg.sv
// adsr_pkg: shared state codes and defaults for the ADSR envelope bank
package adsr_pkg;
   localparam int STATE_W = 3;
   localparam int CURVE_SHIFT_DEF = 4;
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } adsr_state_e;
endpackage

// File: rtl/adsr_step.sv
// adsr_step: combinational next state/level for one voice slot
// ADSR_BANK_EXP_EN adds the exponential distance term; otherwise steps are linear only.
module adsr_step
   import adsr_pkg::*;
#(
   parameter int WIDTH       = 24,
   parameter int CURVE_SHIFT = CURVE_SHIFT_DEF
) (
   input  adsr_state_e      state,
   input  logic [WIDTH-1:0] env,
   input  logic             rise,
   input  logic             fall,
   input  logic [WIDTH-1:0] attack,
   input  logic [WIDTH-1:0] decay,
   input  logic [WIDTH-1:0] rel,
   input  logic [WIDTH-1:0] sustain,
   input  logic             linear,
   output adsr_state_e      state_n,
   output logic [WIDTH-1:0] env_n
);
   localparam logic [WIDTH:0] MAX = {1'b0, {WIDTH{1'b1}}};
   adsr_state_e cur;
   logic [WIDTH:0] e, s, r, step, up, lim;
   // edges redirect the voice first, then the new state takes its step in the same update
   assign cur = rise ? ST_ATTACK : (fall && state != ST_IDLE) ? ST_RELEASE : state;
   assign e = {1'b0, env};
   assign s = {1'b0, sustain};
   assign r = {1'b0, cur == ST_ATTACK ? attack : cur == ST_DECAY ? decay : rel};
`ifdef ADSR_BANK_EXP_EN
   logic [WIDTH:0] dist;
   assign dist = cur == ST_ATTACK ? MAX - e : cur == ST_DECAY ? (e > s ? e - s : '0) : e;
   assign step = linear ? r : (dist >> CURVE_SHIFT) + r;
`else
   logic unused_linear;
   assign unused_linear = linear;
   assign step = r;
`endif
   assign up  = e + step;
   assign lim = s + step;
   always_comb begin
      state_n = cur;
      env_n   = env;
      case (cur)
         ST_ATTACK: begin
            state_n = (r == '0 || up >= MAX) ? ST_DECAY : ST_ATTACK;
            env_n   = (r == '0 || up >= MAX) ? {WIDTH{1'b1}} : up[WIDTH-1:0];
         end
         ST_DECAY: begin
            state_n = (r == '0 || e <= lim) ? ST_SUSTAIN : ST_DECAY;
            env_n   = (r == '0 || e <= lim) ? sustain : env - step[WIDTH-1:0];
         end
         ST_SUSTAIN: env_n = sustain;
         ST_RELEASE: begin
            state_n = (r == '0 || e <= step) ? ST_IDLE : ST_RELEASE;
            env_n   = (r == '0 || e <= step) ? '0 : env - step[WIDTH-1:0];
         end
         default: begin
            state_n = ST_IDLE;
            env_n   = '0;
         end
      endcase
   end
endmodule

// File: rtl/adsr_bank.sv
// adsr_bank: time-multiplexed multi-voice ADSR envelope bank, one voice per cycle per sweep
// ADSR_BANK_EXP_EN enables the exponential step mode selected by Linear.
module adsr_bank
   import adsr_pkg::*;
#(
   parameter int WIDTH       = 24,
   parameter int VOICES      = 4,
   parameter int CURVE_SHIFT = CURVE_SHIFT_DEF
) (
   input  logic                      Clock,
   input  logic                      Reset,
   input  logic                      Tick,
   input  logic [VOICES-1:0]         Gate,
   input  logic                      Linear,
   input  logic [WIDTH-1:0]          Attack,
   input  logic [WIDTH-1:0]          Decay,
   input  logic [WIDTH-1:0]          Release,
   input  logic [WIDTH-1:0]          Sustain,
   output logic [VOICES*WIDTH-1:0]   Envelope,
   output logic [STATE_W*VOICES-1:0] State,
   output logic [VOICES-1:0]         Running,
   output logic                      Busy,
   output logic                      Done
);
   localparam int IW = $clog2(VOICES);
   logic [WIDTH-1:0] env_q [VOICES];
   logic [WIDTH-1:0] env_d [VOICES];
   adsr_state_e state_q [VOICES];
   adsr_state_e state_d [VOICES];
   logic [VOICES-1:0] prev_q, prev_d;
   logic [IW-1:0] idx_q, idx_d;
   logic busy_q, busy_d, done_q, done_d;
   logic g, last;
   logic [WIDTH-1:0] env_n;
   adsr_state_e state_n;
   assign g    = Gate[idx_q];
   assign last = idx_q == IW'(VOICES - 1);
   adsr_step #(.WIDTH(WIDTH), .CURVE_SHIFT(CURVE_SHIFT)) u_step (
      .state   (state_q[idx_q]),
      .env     (env_q[idx_q]),
      .rise    (g & ~prev_q[idx_q]),
      .fall    (~g & prev_q[idx_q]),
      .attack  (Attack),
      .decay   (Decay),
      .rel     (Release),
      .sustain (Sustain),
      .linear  (Linear),
      .state_n (state_n),
      .env_n   (env_n)
   );
   always_comb begin
      env_d   = env_q;
      state_d = state_q;
      prev_d  = prev_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (busy_q) begin
         env_d[idx_q]   = env_n;
         state_d[idx_q] = state_n;
         prev_d[idx_q]  = g;
         idx_d          = last ? '0 : idx_q + 1'b1;
         busy_d         = !last;
         done_d         = last;
      end else if (Tick) begin
         busy_d = 1'b1;
      end
   end
   always_ff @(posedge Clock) begin
      if (Reset) begin
         env_q   <= '{default: '0};
         state_q <= '{default: ST_IDLE};
         prev_q  <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         env_q   <= env_d;
         state_q <= state_d;
         prev_q  <= prev_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
   for (genvar k = 0; k < VOICES; k++) begin : g_out
      assign Envelope[k*WIDTH +: WIDTH]     = env_q[k];
      assign State[k*STATE_W +: STATE_W]    = state_q[k];
      assign Running[k]                     = state_q[k] != ST_IDLE;
   end
   assign Busy = busy_q;
   assign Done = done_q;
endmodule

// File: tb/tb_adsr_bank.sv
// tb_adsr_bank: directed checks of sweep timing, envelope stepping and reset for adsr_bank
module tb_adsr_bank;
   logic clk = 1'b0;
   logic rst, tick, linear;
   logic [3:0] gate;
   logic [7:0] attack, decay, rel, sustain;
   logic [31:0] envelope;
   logic [11:0] state;
   logic [3:0] running;
   logic busy, done;
   int checks = 0;
   int errors = 0;

   adsr_bank #(.WIDTH(8), .VOICES(4), .CURVE_SHIFT(2)) dut (
      .Clock(clk), .Reset(rst), .Tick(tick), .Gate(gate), .Linear(linear),
      .Attack(attack), .Decay(decay), .Release(rel), .Sustain(sustain),
      .Envelope(envelope), .State(state), .Running(running), .Busy(busy), .Done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic sweep();
      int n = 0;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("sweep_done", {31'b0, done}, 32'd1);
   endtask

   logic [7:0] lin_env [12] = '{8'h40, 8'h80, 8'hC0, 8'hFF, 8'hEF, 8'hDF,
                                8'hCF, 8'hBF, 8'hAF, 8'h9F, 8'h8F, 8'h80};
   logic [2:0] lin_st [12] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2,
                               3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};

   initial begin
      int busy_n, done_n;
      tick = 1'b0; gate = '0; linear = 1'b1;
      attack = 8'h40; decay = 8'h10; rel = 8'h10; sustain = 8'h80;
      @(negedge clk);
      do_reset();
      check("rst_env", envelope, 32'h0);
      check("rst_state", {20'b0, state}, 32'h0);
      check("rst_running", {28'b0, running}, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_done", {31'b0, done}, 32'h0);

      gate = 4'b0001;
      for (int i = 0; i < 12; i++) begin
         sweep();
         check($sformatf("lin_env%0d", i), {24'b0, envelope[7:0]}, {24'b0, lin_env[i]});
         check($sformatf("lin_st%0d", i), {29'b0, state[2:0]}, {29'b0, lin_st[i]});
      end
      sweep();
      check("sus_hold", {24'b0, envelope[7:0]}, 32'h80);
      check("sus_state", {29'b0, state[2:0]}, 32'd3);
      check("others_env", {8'b0, envelope[31:8]}, 32'h0);
      check("others_st", {23'b0, state[11:3]}, 32'h0);
      check("running_v0", {28'b0, running}, 32'h1);

      rel = 8'h00; gate = 4'b0000;
      sweep();
      check("rel0_env", {24'b0, envelope[7:0]}, 32'h0);
      check("rel0_state", {29'b0, state[2:0]}, 32'd0);
      check("rel0_running", {28'b0, running}, 32'h0);

      attack = 8'h80; decay = 8'h00; gate = 4'b0001;
      sweep();
      check("a80_env", {24'b0, envelope[7:0]}, 32'h80);
      sweep();
      check("a80_peak", {24'b0, envelope[7:0]}, 32'hFF);
      sweep();
      check("d0_env", {24'b0, envelope[7:0]}, 32'h80);
      check("d0_state", {29'b0, state[2:0]}, 32'd3);
      rel = 8'h10; gate = 4'b0000;
      sweep();
      check("rel_env1", {24'b0, envelope[7:0]}, 32'h70);
      check("rel_state1", {29'b0, state[2:0]}, 32'd4);
      sweep();
      sweep();
      check("rel_env3", {24'b0, envelope[7:0]}, 32'h50);
      attack = 8'h20; gate = 4'b0001;
      sweep();
      check("legato_env", {24'b0, envelope[7:0]}, 32'h70);
      check("legato_state", {29'b0, state[2:0]}, 32'd1);

      do_reset();
      linear = 1'b0; attack = 8'h01; gate = 4'b0001;
      sweep();
`ifdef ADSR_BANK_EXP_EN
      check("exp_env1", {24'b0, envelope[7:0]}, 32'h40);
      sweep();
      check("exp_env2", {24'b0, envelope[7:0]}, 32'h70);
`else
      check("exp_env1", {24'b0, envelope[7:0]}, 32'h01);
      sweep();
      check("exp_env2", {24'b0, envelope[7:0]}, 32'h02);
`endif

      do_reset();
      linear = 1'b1; gate = 4'b0000;
      busy_n = 0; done_n = 0;
      tick = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         tick = (i == 1);
         busy_n += int'(busy);
         done_n += int'(done);
      end
      check("drop_busy_cycles", busy_n, 4);
      check("drop_done_pulses", done_n, 1);

      attack = 8'h40; gate = 4'b1111;
      sweep();
      check("all_env", envelope, 32'h40404040);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_env", envelope, 32'h0);
      check("mid_rst_state", {20'b0, state}, 32'h0);
      check("mid_rst_running", {28'b0, running}, 32'h0);
      check("mid_rst_busy", {31'b0, busy}, 32'h0);
      check("mid_rst_done", {31'b0, done}, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_done", {31'b0, done}, 32'h0);
      check("post_rst_busy", {31'b0, busy}, 32'h0);
      sweep();
      check("post_rst_env", envelope, 32'h40404040);
      check("post_rst_running", {28'b0, running}, 32'hF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
